jump_target_gen: RTL and testbench
==================================

Name: jump_target_gen

Overview:
- Parametrised jump-target formation unit for the multi-cycle CPU datapath.
- Forms the target for three jump types:
  - J/JAL: {PC upper bits, instr_index, ALIGN zero bits}.
  - JR: register target.
- Latches the PC upper bits at instruction fetch and registers the result.
- Presents the target to the PC-source mux with a valid/ack handshake, so the controller can issue it in one state and consume it in a later one.

Parameters:
- ADDR_W, 32, PC/target width.
- IDX_W, 26, instruction index field width.
- ALIGN, 2, number of zero bits appended (word alignment).
- Derived localparam HI_W = ADDR_W-IDX_W-ALIGN (default 4); must be >=0; HI_W==0 omits the PC field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  ADDR_W  current PC (already PC+4 after fetch).
- pc_ld  in  1  latch pc[ADDR_W-1:ADDR_W-HI_W] (asserted with IR write).
- instr_index  in  IDX_W  jump index field from IR.
- reg_target  in  ADDR_W  rs value for JR.
- mode  in  2  00=J, 01=JAL, 10=JR, 11=reserved.
- req  in  1  start target computation.
- ack  in  1  controller consumed target.
- target  out  ADDR_W  registered jump target.
- link  out  ADDR_W  registered return address (latched pc) for JAL, else 0.
- link_we  out  1  high with valid when mode==JAL.
- valid  out  1  target/link valid.
- busy  out  1  request in progress (state != IDLE).
- err  out  1  reserved mode (or misalignment, see Optional Feature).

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; target, link, pc_hi = 0; valid, link_we, busy, err = 0.
- pc_ld:
  - Latches pc_hi and pc_full (link source) on any cycle, in any state.
  - A pc_ld in the same cycle as req: the request uses the newly latched value (bypass).
- FSM:
  - IDLE: on req, capture mode, instr_index, reg_target -> CALC; busy=1 next cycle.
  - CALC (1 cycle): compute and register outputs -> HOLD; valid=1 the cycle after entering CALC.
    - J: target={pc_hi, instr_index, ALIGN'b0}.
    - JAL: as J, plus link=pc_full, link_we=1.
    - JR: target=reg_target.
    - Reserved mode: target=0, err=1.
  - HOLD: outputs stable while ack=0.
    - ack=1: valid, link_we, err -> 0 next cycle; state -> IDLE.
    - ack with req in the same cycle: state -> CALC directly (back-to-back); valid drops for exactly one cycle.
- Latency: req at cycle N -> valid at N+2.
- Handshake rules:
  - req while busy (CALC/HOLD, except the ack cycle) is ignored; no queuing.
  - ack in IDLE or CALC is ignored.
- Arithmetic: pure concatenation, no carry; the upper bits never change from the latched pc_hi (region wrap is by construction).
- Reset mid-operation: synchronous rst overrides any state; outputs clear on that edge; ack/req in the same cycle are ignored.
- target and link retain their value after ack until the next CALC.

Optional Feature:
- Macro: JUMP_ALIGN_CHECK_EN.
- Defined: in CALC for JR, if reg_target[ALIGN-1:0] != 0:
  - err=1 with valid;
  - target is still reg_target;
  - the controller raises the address exception.
- Undefined:
  - The check logic is absent.
  - JR never sets err.
  - Low bits pass through unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - mode encodings: JMODE_J=2'b00, JMODE_JAL=2'b01, JMODE_JR=2'b10, JMODE_RSV=2'b11;
  - FSM state constants: S_IDLE, S_CALC, S_HOLD;
  - defaults ADDR_W=32, ALIGN=2.
- Sub-module jt_concat (combinational {hi, idx, zeros} with HI_W==0 generate branch) is natural; reusable for branch/target formatting.

Test Plan:
- rst, then pc=0x3000_0004 with pc_ld; req, mode=J, instr_index=0x0ABCDEF -> valid at N+2, target=0x32AF_37BC, link_we=0, err=0.
- pc=0xF000_0008 pc_ld; req, mode=JAL, index=0x3FFFFFF -> target=0xFFFF_FFFC, link=0xF000_0008, link_we=1; hold ack=0 for 5 cycles -> outputs stable; ack -> valid=0 next cycle.
- mode=JR, reg_target=0x0040_0020 -> target=0x0040_0020. With JUMP_ALIGN_CHECK_EN, reg_target=0x0040_0022 -> err=1; without the macro, err=0 and target=0x0040_0022.
- mode=11 -> err=1, target=0; req during HOLD ignored, target unchanged; ack+req same cycle -> valid low 1 cycle, then new result.
- rst asserted during CALC -> next edge valid=0, busy=0, target=0; a subsequent req completes normally in 2 cycles.
- Parameter sweep ADDR_W=32, IDX_W=30, ALIGN=2 (HI_W=0): index=0x1 -> target=0x0000_0004.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: jump mode encodings, jump-unit FSM states, default widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    JMODE_J   = 2'b00,
    JMODE_JAL = 2'b01,
    JMODE_JR  = 2'b10,
    JMODE_RSV = 2'b11
  } jmode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_HOLD = 2'b10
  } jstate_t;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_IDX_W  = 26;
  localparam int unsigned DEF_ALIGN  = 2;

endpackage

// File: rtl/jt_concat.sv
// Combinational target formatter: {hi, idx, ALIGN zero bits}; the hi field vanishes when HI_W==0.
module jt_concat #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 26,
  parameter int unsigned ALIGN  = 2,
  parameter int unsigned HI_W   = ADDR_W - IDX_W - ALIGN,
  parameter int unsigned HI_PW  = (HI_W > 0) ? HI_W : 1
) (
  input  logic [HI_PW-1:0]  hi,
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] low;

  // Shifting rather than replicating zeros keeps ALIGN==0 legal.
  assign low = ADDR_W'(idx) << ALIGN;

  generate
    if (HI_W > 0) begin : g_hi
      assign addr = {hi, low[ADDR_W-HI_W-1:0]};
    end else begin : g_nohi
      logic unused_hi;
      assign unused_hi = ^hi;
      assign addr      = low;
    end
  endgenerate

endmodule

// File: rtl/jump_target_gen.sv
// J/JAL/JR jump-target unit with registered outputs and valid/ack handshake.
// Optional JR alignment check enabled by defining JUMP_ALIGN_CHECK_EN.
module jump_target_gen
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned ALIGN  = DEF_ALIGN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_ld,
  input  logic [IDX_W-1:0]  instr_index,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic [1:0]        mode,
  input  logic              req,
  input  logic              ack,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] link,
  output logic              link_we,
  output logic              valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned HI_W  = ADDR_W - IDX_W - ALIGN;
  localparam int unsigned HI_PW = (HI_W > 0) ? HI_W : 1;

  jstate_t           state;
  logic [HI_PW-1:0]  pc_hi, pc_slice, eff_hi, r_hi;
  logic [ADDR_W-1:0] pc_full, eff_full, r_full, r_rt;
  logic [IDX_W-1:0]  r_idx;
  jmode_t            r_mode;
  logic [ADDR_W-1:0] jtarget;
  logic              align_err;
  logic              take;

  generate
    if (HI_W > 0) begin : g_slice
      assign pc_slice = pc[ADDR_W-1 -: HI_PW];
    end else begin : g_noslice
      assign pc_slice = '0;
    end
  endgenerate

  // A pc_ld coinciding with req is forwarded so the request sees the new PC.
  always_comb begin
    eff_hi   = pc_ld ? pc_slice : pc_hi;
    eff_full = pc_ld ? pc : pc_full;
    take     = req && ((state == S_IDLE) || ((state == S_HOLD) && ack));
  end

`ifdef JUMP_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN) - 64'd1);
  assign align_err = |(r_rt & ALIGN_MASK);
`else
  assign align_err = 1'b0;
`endif

  jt_concat #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .ALIGN  (ALIGN)
  ) u_concat (
    .hi   (r_hi),
    .idx  (r_idx),
    .addr (jtarget)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_hi   <= '0;
      pc_full <= '0;
      r_hi    <= '0;
      r_full  <= '0;
      r_rt    <= '0;
      r_idx   <= '0;
      r_mode  <= JMODE_J;
      target  <= '0;
      link    <= '0;
      link_we <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (pc_ld) begin
        pc_hi   <= pc_slice;
        pc_full <= pc;
      end

      if (take) begin
        r_hi   <= eff_hi;
        r_full <= eff_full;
        r_rt   <= reg_target;
        r_idx  <= instr_index;
        r_mode <= jmode_t'(mode);
      end

      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_CALC;
            busy  <= 1'b1;
          end
        end
        S_CALC: begin
          state <= S_HOLD;
          valid <= 1'b1;
          case (r_mode)
            JMODE_J: begin
              target  <= jtarget;
              link    <= '0;
              link_we <= 1'b0;
              err     <= 1'b0;
            end
            JMODE_JAL: begin
              target  <= jtarget;
              link    <= r_full;
              link_we <= 1'b1;
              err     <= 1'b0;
            end
            JMODE_JR: begin
              target  <= r_rt;
              link    <= '0;
              link_we <= 1'b0;
              err     <= align_err;
            end
            default: begin
              target  <= '0;
              link    <= '0;
              link_we <= 1'b0;
              err     <= 1'b1;
            end
          endcase
        end
        S_HOLD: begin
          if (ack) begin
            valid   <= 1'b0;
            link_we <= 1'b0;
            err     <= 1'b0;
            if (req) begin
              state <= S_CALC;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_target_gen.sv
// Scoreboard bench for jump_target_gen: default build plus a HI_W==0 instance.
module tb_jump_target_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_ld;
  logic [25:0] instr_index;
  logic [31:0] reg_target;
  logic [1:0]  mode;
  logic        req, ack;
  logic [31:0] target, link;
  logic        link_we, valid, busy, err;

  logic [29:0] idx2;
  logic        req2, ack2;
  logic [31:0] target2, link2;
  logic        link_we2, valid2, busy2, err2;

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] l;
    logic        we;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic pv = 1'b0;

  always #5 clk = ~clk;

  jump_target_gen #(.ADDR_W(32), .IDX_W(26), .ALIGN(2)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_ld(pc_ld), .instr_index(instr_index),
    .reg_target(reg_target), .mode(mode), .req(req), .ack(ack),
    .target(target), .link(link), .link_we(link_we), .valid(valid),
    .busy(busy), .err(err)
  );

  jump_target_gen #(.ADDR_W(32), .IDX_W(30), .ALIGN(2)) dut2 (
    .clk(clk), .rst(rst), .pc(pc), .pc_ld(pc_ld), .instr_index(idx2),
    .reg_target(reg_target), .mode(2'b00), .req(req2), .ack(ack2),
    .target(target2), .link(link2), .link_we(link_we2), .valid(valid2),
    .busy(busy2), .err(err2)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] m, input logic [25:0] idx, input logic [31:0] rt,
                       input exp_t e, input bit push);
    mode        = m;
    instr_index = idx;
    reg_target  = rt;
    req         = 1'b1;
    if (push) q.push_back(e);
    step();
    req = 1'b0;
  endtask

  task automatic latency(input string name);
    chk({name, "_valid_n1"}, {31'd0, valid}, 32'd0);
    chk({name, "_busy_n1"}, {31'd0, busy}, 32'd1);
    step();
    chk({name, "_valid_n2"}, {31'd0, valid}, 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_valid_drop", {31'd0, valid}, 32'd0);
  endtask

  // Monitor: each rising edge of valid is one new result.
  always @(negedge clk) begin
    if (valid && !pv) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got target 0x%08h expected no result", target);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_target", target, e.t);
        chk("sb_link", link, e.l);
        chk("sb_link_we", {31'd0, link_we}, {31'd0, e.we});
        chk("sb_err", {31'd0, err}, {31'd0, e.e});
      end
    end
    pv = valid;
  end

  initial begin
    rst = 1'b1; pc = '0; pc_ld = 1'b0; instr_index = '0; reg_target = '0;
    mode = 2'b00; req = 1'b0; ack = 1'b0; idx2 = '0; req2 = 1'b0; ack2 = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_target", target, 32'h0);
    chk("rst_link", link, 32'h0);
    chk("rst_flags", {28'd0, valid, busy, err, link_we}, 32'h0);

    // J
    pc = 32'h3000_0004; pc_ld = 1'b1; step(); pc_ld = 1'b0;
    issue(2'b00, 26'h0ABCDEF, 32'h0, '{32'h32AF_37BC, 32'h0, 1'b0, 1'b0}, 1'b1);
    latency("j");
    do_ack();
    chk("j_busy_after_ack", {31'd0, busy}, 32'd0);

    // JAL with pc_ld in the request cycle (bypass)
    pc = 32'hF000_0008; pc_ld = 1'b1;
    issue(2'b01, 26'h3FFFFFF, 32'h0, '{32'hFFFF_FFFC, 32'hF000_0008, 1'b1, 1'b0}, 1'b1);
    pc_ld = 1'b0;
    latency("jal");
    pc = 32'h1234_5678; pc_ld = 1'b1; step(); pc_ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("jal_hold_target", target, 32'hFFFF_FFFC);
      chk("jal_hold_flags", {30'd0, valid, link_we}, 32'd3);
      step();
    end
    do_ack();
    chk("jal_we_drop", {31'd0, link_we}, 32'd0);
    chk("jal_target_retained", target, 32'hFFFF_FFFC);

    // JR aligned and misaligned
    issue(2'b10, 26'h0, 32'h0040_0020, '{32'h0040_0020, 32'h0, 1'b0, 1'b0}, 1'b1);
    latency("jr");
    do_ack();
`ifdef JUMP_ALIGN_CHECK_EN
    issue(2'b10, 26'h0, 32'h0040_0022, '{32'h0040_0022, 32'h0, 1'b0, 1'b1}, 1'b1);
`else
    issue(2'b10, 26'h0, 32'h0040_0022, '{32'h0040_0022, 32'h0, 1'b0, 1'b0}, 1'b1);
`endif
    latency("jr_mis");
    do_ack();

    // Reserved mode, ignored req in HOLD, then back-to-back ack+req
    issue(2'b11, 26'h1, 32'hDEAD_BEEF, '{32'h0, 32'h0, 1'b0, 1'b1}, 1'b1);
    latency("rsv");
    mode = 2'b10; reg_target = 32'h5555_5554; req = 1'b1;
    step(2);
    chk("hold_req_target", target, 32'h0);
    chk("hold_req_flags", {30'd0, valid, err}, 32'd3);
    ack = 1'b1;
    issue(2'b00, 26'h0000001, 32'h0, '{32'h1000_0004, 32'h0, 1'b0, 1'b0}, 1'b1);
    ack = 1'b0;
    chk("b2b_gap_valid", {31'd0, valid}, 32'd0);
    chk("b2b_gap_busy", {31'd0, busy}, 32'd1);
    step();
    chk("b2b_valid", {31'd0, valid}, 32'd1);
    do_ack();

    // Reset while in CALC
    issue(2'b00, 26'h0000002, 32'h0, '{32'h0, 32'h0, 1'b0, 1'b0}, 1'b0);
    rst = 1'b1; ack = 1'b1; req = 1'b1; step(); rst = 1'b0; ack = 1'b0; req = 1'b0;
    chk("rst_calc_target", target, 32'h0);
    chk("rst_calc_flags", {28'd0, valid, busy, err, link_we}, 32'h0);
    issue(2'b00, 26'h0000010, 32'h0, '{32'h0000_0040, 32'h0, 1'b0, 1'b0}, 1'b1);
    latency("post_rst");
    do_ack();

    // HI_W==0 instance
    idx2 = 30'h1; req2 = 1'b1; step(); req2 = 1'b0;
    begin
      int n = 0;
      while (!valid2 && n < 4) begin step(); n++; end
      chk("hi0_timeout", {31'd0, valid2}, 32'd1);
    end
    chk("hi0_target", target2, 32'h0000_0004);
    ack2 = 1'b1; step(); ack2 = 1'b0;
    idx2 = 30'h3FFF_FFFF; req2 = 1'b1; step(); req2 = 1'b0;
    step();
    chk("hi0_target_max", target2, 32'hFFFF_FFFC);
    ack2 = 1'b1; step(); ack2 = 1'b0;

    step(2);
    chk("sb_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
